// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: operand/result widths, opcodes and FSM state encodings.
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int OP_W   = 2;
    localparam int RES_W  = 8;

    localparam logic [OP_W-1:0] ALU_ADD = 2'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 2'd1;
    localparam logic [OP_W-1:0] ALU_MUL = 2'd2;
    localparam logic [OP_W-1:0] ALU_AND = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_PIPE  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU producing an 8-bit result (ADD, SUB mod 256, MUL, AND).
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = {{(RES_W-OPND_W){1'b0}}, a};
    assign b_ext = {{(RES_W-OPND_W){1'b0}}, b};

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a_ext + b_ext;
            ALU_SUB: result = a_ext - b_ext;
            ALU_MUL: result = a_ext * b_ext;
            ALU_AND: result = a_ext & b_ext;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Optional output pipeline stage enabled by macro ALU_ARB_OUT_PIPE_EN.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [OPND_W-1:0] a0,
    input  logic [OPND_W-1:0] b0,
    input  logic [OP_W-1:0]   op0,
    input  logic [OPND_W-1:0] a1,
    input  logic [OPND_W-1:0] b1,
    input  logic [OP_W-1:0]   op1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [RES_W-1:0]  rslt,
    output logic              rslt_vld,
    output logic              rslt_id,
    output logic              busy,
    output logic [RES_W-1:0]  op_cnt
);

    logic [2:0]        state;
    logic              win_id;
    logic              last_id;
    logic              pick;
    logic [OPND_W-1:0] opa_p0;
    logic [OPND_W-1:0] opb_p0;
    logic [OP_W-1:0]   opc_p0;
    logic [RES_W-1:0]  alu_res;
`ifdef ALU_ARB_OUT_PIPE_EN
    logic [RES_W-1:0]  alu_p1;
`endif

    // On contention the requester not served last wins; a lone request always wins.
    assign pick = (req0 && req1) ? ~last_id : req1;

    alu_arbiter_alu u_alu (
        .a      (opa_p0),
        .b      (opb_p0),
        .op     (opc_p0),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            win_id  <= 1'b0;
            last_id <= 1'b1;
            opa_p0  <= '0;
            opb_p0  <= '0;
            opc_p0  <= '0;
            rslt    <= '0;
            op_cnt  <= '0;
`ifdef ALU_ARB_OUT_PIPE_EN
            alu_p1  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        win_id <= pick;
                        state  <= ST_GRANT;
                    end
                end
                // Operand capture stage
                ST_GRANT: begin
                    opa_p0  <= win_id ? a1  : a0;
                    opb_p0  <= win_id ? b1  : b0;
                    opc_p0  <= win_id ? op1 : op0;
                    last_id <= win_id;
                    state   <= ST_EXEC;
                end
`ifdef ALU_ARB_OUT_PIPE_EN
                // ALU output stage, then copy to the result bus
                ST_EXEC: begin
                    alu_p1 <= alu_res;
                    state  <= ST_PIPE;
                end
                ST_PIPE: begin
                    rslt  <= alu_p1;
                    state <= ST_RESP;
                end
`else
                // ALU output stage
                ST_EXEC: begin
                    rslt  <= alu_res;
                    state <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    op_cnt <= op_cnt + 8'd1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gnt0     = (state == ST_GRANT) && !win_id;
    assign gnt1     = (state == ST_GRANT) &&  win_id;
    assign rslt_vld = (state == ST_RESP);
    assign rslt_id  = (state == ST_RESP) && win_id;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand sequences and randomized ops
// checked against a transaction-level model (round-robin winner, integer ALU math, op count).
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] op0 = '0, op1 = '0;
    logic       gnt0, gnt1, rslt_vld, rslt_id, busy;
    logic [7:0] rslt, op_cnt;

`ifdef ALU_ARB_OUT_PIPE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int m_last = 1;
    int m_cnt  = 0;

    typedef struct {
        bit         r0;
        bit         r1;
        logic [3:0] x0, y0;
        logic [1:0] o0;
        logic [3:0] x1, y1;
        logic [1:0] o1;
        bit         eid;
        logic [7:0] erslt;
    } vec_t;

    vec_t tbl[4];

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .op0(op0),
        .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rslt(rslt), .rslt_vld(rslt_vld), .rslt_id(rslt_id),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0: return a + b;
            1: return (a - b + 256) % 256;
            2: return a * b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
        m_cnt  = 0;
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the following idle cycle.
    task automatic do_op(input bit r0, input bit r1,
                         input logic [3:0] x0, input logic [3:0] y0, input logic [1:0] o0,
                         input logic [3:0] x1, input logic [3:0] y1, input logic [1:0] o1,
                         input bit hold, input bit use_exp, input bit eid, input logic [7:0] erslt);
        int w, exp_r, cyc;
        w = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
        exp_r = (w == 1) ? ref_alu(x1, y1, o1) : ref_alu(x0, y0, o0);
        if (use_exp) begin
            w = eid;
            exp_r = erslt;
        end
        m_last = w;
        m_cnt  = (m_cnt + 1) % 256;

        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; op0 = o0;
        a1 = x1; b1 = y1; op1 = o1;
        @(negedge clk);
        check("gnt0", gnt0, (w == 0) ? 1 : 0);
        check("gnt1", gnt1, (w == 1) ? 1 : 0);
        check("busy_in_grant", busy, 1);
        if (!hold) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        cyc = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            cyc++;
            if (rslt_vld) break;
        end
        check("rslt_latency", cyc, LAT - 1);
        check("rslt", rslt, exp_r);
        check("rslt_id", rslt_id, w);
        @(negedge clk);
        check("op_cnt", op_cnt, m_cnt);
        check("busy_in_idle", busy, 0);
        check("rslt_hold", rslt, exp_r);
    endtask

    initial begin
        tbl[0] = '{1, 0, 4'd9,  4'd6,  2'd0, 4'd0,  4'd0,  2'd0, 0, 8'd15};
        tbl[1] = '{0, 1, 4'd0,  4'd0,  2'd0, 4'd4,  4'd7,  2'd1, 1, 8'hFD};
        tbl[2] = '{1, 0, 4'd15, 4'd15, 2'd2, 4'd0,  4'd0,  2'd0, 0, 8'd225};
        tbl[3] = '{0, 1, 4'd0,  4'd0,  2'd0, 4'd12, 4'd10, 2'd3, 1, 8'd8};

        do_reset();
        // Reset state (inputs idle for one extra cycle)
        check("rst_busy", busy, 0);
        check("rst_vld", rslt_vld, 0);
        check("rst_rslt", rslt, 0);
        check("rst_op_cnt", op_cnt, 0);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_id", rslt_id, 0);

        // Simultaneous held requests right after reset: 0,1,0,1
        for (int k = 0; k < 4; k++)
            do_op(1, 1, 4'd9, 4'd6, 2'd0, 4'd4, 4'd7, 2'd1, 1, 1, k[0], k[0] ? 8'hFD : 8'd15);
        req0 = 1'b0; req1 = 1'b0;

        // Directed table
        for (int k = 0; k < 4; k++)
            do_op(tbl[k].r0, tbl[k].r1, tbl[k].x0, tbl[k].y0, tbl[k].o0,
                  tbl[k].x1, tbl[k].y1, tbl[k].o1, 0, 1, tbl[k].eid, tbl[k].erslt);

        // Reset during EXEC discards the operation
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd15; op0 = 2'd2;
        @(negedge clk);
        check("mid_gnt0", gnt0, 1);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
        m_cnt  = 0;
        check("mid_busy", busy, 0);
        check("mid_vld", rslt_vld, 0);
        check("mid_rslt", rslt, 0);
        check("mid_op_cnt", op_cnt, 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rslt_vld) seen++;
            end
            check("mid_no_vld", seen, 0);
        end
        do_op(1, 1, 4'd3, 4'd5, 2'd0, 4'd4, 4'd7, 2'd1, 0, 1, 0, 8'd8);

        // Randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            int rr;
            rr = $urandom_range(1, 3);
            do_op(rr[0], rr[1], 4'($urandom), 4'($urandom), 2'($urandom),
                  4'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 1), 0, 0, 8'd0);
        end

        // Counter wrap after 256 back-to-back operations
        do_reset();
        for (int k = 0; k < 256; k++)
            do_op(1, 0, 4'($urandom), 4'($urandom), 2'($urandom),
                  4'd0, 4'd0, 2'd0, 1, 0, 0, 8'd0);
        req0 = 1'b0;
        check("wrap_op_cnt", op_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (operands 4 bit, op 2 bit, result 8 bit).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0 / req1  input  1  request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  input  4  operands of requester 0 / 1.
REQ-006 op0 / op1  input  2  ALU opcode of requester 0 / 1.
REQ-007 gnt0 / gnt1  output  1  one-cycle grant pulse; operands captured in that cycle.
REQ-008 rslt  output  8  shared result bus.
REQ-009 rslt_vld  output  1  one-cycle pulse; rslt valid.
REQ-010 rslt_id  output  1  owner of rslt (0/1); meaningful only with rslt_vld.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 op_cnt  output  8  completed-operation count, wraps 255->0.

Function
REQ-013 FSM states: IDLE, GRANT, EXEC, RESP (plus PIPE, see REQ-026); one-hot or binary at implementer's choice.
REQ-014 IDLE: if any req high at an edge -> GRANT; else stay IDLE.
REQ-015 Requests are sampled only in IDLE; req changes in other states are ignored.
REQ-016 Arbitration is round-robin: on simultaneous req0 and req1, grant the requester not served last; last_id resets to 1, so requester 0 wins first.
REQ-017 Single request: grant it, regardless of last_id.
REQ-018 GRANT: exactly one gnt high for one cycle; the selected a/b/op are registered at the end of GRANT; last_id updates to the winner; -> EXEC.
REQ-019 EXEC: registered operands drive one shared ALU instance; ALU output captured into the rslt register at the end of EXEC; -> RESP.
REQ-020 RESP: rslt_vld=1 and rslt_id=winner for exactly one cycle; op_cnt increments; -> IDLE.
REQ-021 Latency: req high at edge N -> gnt in cycle N+1 -> rslt_vld in cycle N+3; back-to-back throughput is one operation per 4 cycles.
REQ-022 rslt holds its last value until the next RESP; requesters must hold req until their gnt, then may drop or re-raise it.
REQ-023 Arithmetic (ALU contract): ADD = zero-extended a+b; SUB = (a-b) mod 256; MUL = a*b (max 225); AND = zero-extended a&b.

Reset
REQ-024 rst_n low at an edge, in any state including mid-operation: state=IDLE, gnt0=gnt1=0, rslt=0, rslt_vld=0, rslt_id=0, busy=0, op_cnt=0, last_id=1, operand registers=0; an in-flight operation is discarded with no rslt_vld.
REQ-025 The first request is sampled on the first edge with rst_n high.

Configuration
REQ-026 Macro ALU_ARB_OUT_PIPE_EN defined: PIPE state is inserted between EXEC and RESP, with the ALU output registered in EXEC and copied to rslt in PIPE; latency becomes N+4, throughput 1 op per 5 cycles.
REQ-027 Macro ALU_ARB_OUT_PIPE_EN undefined: no PIPE state; timing exactly as REQ-021.

Structure
REQ-028 Shared package alu_pkg holds the opcode constants (ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_MUL=2'd2, ALU_AND=2'd3), the FSM state encodings and the width constants (4/2/8).
REQ-029 One sub-module: the existing ALU (ports a, b, op, result), instantiated once; the arbiter adds no datapath arithmetic beyond op_cnt.

Verification
REQ-030 Single request, macro undefined: req0=1 with a0=9, b0=6, op0=ADD at edge N -> gnt0 in cycle N+1, rslt=15, rslt_vld and rslt_id=0 in cycle N+3, op_cnt=1.
REQ-031 Simultaneous requests after reset: req0 and req1 both held -> grants alternate 0,1,0,1; rslt_id follows; requester 1 with a1=4, b1=7, op1=SUB -> rslt=8'hFD.
REQ-032 Boundary MUL: a=15, b=15, op=MUL -> rslt=225; AND: a=12, b=10 -> rslt=8.
REQ-033 Reset mid-operation: rst_n low during EXEC -> next cycle IDLE, no rslt_vld, rslt=0, op_cnt=0; a subsequent simultaneous request is granted to 0.
REQ-034 Counter wrap: 256 back-to-back operations -> op_cnt returns to 0; busy low only in IDLE cycles.
REQ-035 Macro defined: rerun REQ-030 -> rslt_vld in cycle N+4, identical value.
